// File: rtl/router_1xn_if.sv
// Byte-serial input / per-channel output bundle for router_1xn.
interface router_1xn_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
);
    logic [DATA_W-1:0]        data_in;
    logic                     pkt_valid;
    logic                     busy;
    logic [NUM_CH-1:0]        read_en;
    logic [NUM_CH-1:0]        valid_out;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic                     error;
    logic                     addr_err;

    modport master (
        output data_in, pkt_valid, read_en,
        input  busy, valid_out, data_out, error, addr_err
    );

    modport slave (
        input  data_in, pkt_valid, read_en,
        output busy, valid_out, data_out, error, addr_err
    );
endinterface

// File: rtl/router_1xn.sv
// 1xN packet router: header-addressed per-channel FIFOs, parity check, bad-address drop.
// Define ROUTER_TIMEOUT_FLUSH_EN to add per-channel idle-timeout flushing.
module router_1xn #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = $clog2(NUM_CH),
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input logic        clk,
    input logic        rstn,
    router_1xn_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NSEL = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   dest, dest_reg, wsel;
    logic                dest_ok, busy, accept, wr_any;
    logic [DATA_W-1:0]   parity;
    logic                error_q, addr_err_q;

    logic [PW:0]         wr_ptr [NUM_CH];
    logic [PW:0]         rd_ptr [NUM_CH];
    logic [DATA_W-1:0]   mem    [NUM_CH][DEPTH];
    logic [NUM_CH-1:0]   full, empty, push, pop, flush, wr_en;
    logic [NSEL-1:0]     full_x, flush_x;
    logic [NUM_CH-1:0]   valid_out;
    logic [NUM_CH*DATA_W-1:0] data_out;

    assign dest    = bus.data_in[ADDR_W-1:0];
    assign dest_ok = {1'b0, dest} < NUM_CH_L;

    always_comb begin
        full   = '0;
        empty  = '0;
        full_x = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            empty[k]  = wr_ptr[k] == rd_ptr[k];
            full[k]   = (wr_ptr[k][PW] != rd_ptr[k][PW]) &&
                        (wr_ptr[k][PW-1:0] == rd_ptr[k][PW-1:0]);
            full_x[k] = full[k];
        end
    end

    always_comb begin
        flush_x = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) flush_x[k] = flush[k];
    end

`ifdef ROUTER_TIMEOUT_FLUSH_EN
    logic [9:0] cnt [NUM_CH];

    always_comb begin
        flush = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            flush[k] = !empty[k] && !bus.read_en[k] && (cnt[k] == 10'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (empty[k] || bus.read_en[k] || flush[k]) cnt[k] <= '0;
                else                                        cnt[k] <= cnt[k] + 10'd1;
            end
        end
    end
`else
    assign flush = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // A flush hitting the target FIFO mid-packet diverts the remainder to DROP;
    // if the parity word lands in that same cycle the packet simply ends unchecked.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.pkt_valid) begin
                if (!dest_ok)    state_nx = DROP;
                else if (accept) state_nx = flush_x[dest] ? DROP : LOAD;
            end
            LOAD: begin
                if (accept && !bus.pkt_valid) state_nx = CHECK;
                else if (flush_x[dest_reg])   state_nx = DROP;
            end
            CHECK:   state_nx = IDLE;
            DROP:    if (!bus.pkt_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        wr_any = 1'b0;
        wsel   = dest_reg;
        case (state)
            IDLE: begin
                busy   = bus.pkt_valid && dest_ok && full_x[dest];
                wr_any = bus.pkt_valid && dest_ok && !full_x[dest];
                wsel   = dest;
            end
            LOAD: begin
                busy   = full_x[dest_reg];
                wr_any = !full_x[dest_reg];
            end
            CHECK:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
        accept = (state != CHECK) && !busy;
        wr_en  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            wr_en[k] = wr_any && (wsel == ADDR_W'(k));
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            push[k] = wr_en[k] && !flush[k];
            pop[k]  = bus.read_en[k] && !empty[k] && !flush[k];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dest_reg   <= '0;
            parity     <= '0;
            error_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            error_q    <= 1'b0;
            addr_err_q <= 1'b0;
            case (state)
                IDLE: if (bus.pkt_valid) begin
                    if (!dest_ok) addr_err_q <= 1'b1;
                    else if (accept) begin
                        dest_reg <= dest;
                        parity   <= bus.data_in;
                    end
                end
                LOAD: if (accept) begin
                    if (bus.pkt_valid) parity  <= parity ^ bus.data_in;
                    else               error_q <= (bus.data_in != parity) && !flush_x[dest_reg];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (flush[k]) begin
                    wr_ptr[k] <= '0;
                    rd_ptr[k] <= '0;
                end else begin
                    if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                    if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_CH; k++)
            if (push[k]) mem[k][wr_ptr[k][PW-1:0]] <= bus.data_in;
    end

    always_comb begin
        valid_out = '0;
        data_out  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            valid_out[k] = !empty[k];
            if (!empty[k]) data_out[k*DATA_W +: DATA_W] = mem[k][rd_ptr[k][PW-1:0]];
        end
    end

    assign bus.busy      = busy;
    assign bus.valid_out = valid_out;
    assign bus.data_out  = data_out;
    assign bus.error     = error_q;
    assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_router_1xn.sv
// Randomized bench for router_1xn against a queue-based per-cycle packet model.
module tb_router_1xn;
    localparam int DW      = 8;
    localparam int NC      = 3;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;
`ifdef ROUTER_TIMEOUT_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    router_1xn_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

    router_1xn #(
        .DATA_W (DW),
        .NUM_CH (NC),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // Model: stored words per channel, idle counters and packet progress flags.
    logic [7:0] q [NC][$];
    int         tcnt [NC];
    bit         in_pkt, dropping, bubble, m_err, m_aerr;
    int         mdest;
    logic [7:0] mpar;
    logic [2:0] rd_req;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            q[k].delete();
            tcnt[k] = 0;
        end
        in_pkt = 0; dropping = 0; bubble = 0; m_err = 0; m_aerr = 0;
        mdest = 0; mpar = '0;
    endtask

    function automatic bit exp_busy(input logic [7:0] d, input logic pv);
        int dst;
        dst = int'(d[1:0]);
        if (bubble)   return 1'b1;
        if (dropping) return 1'b0;
        if (in_pkt)   return q[mdest].size() == DEPTH;
        return pv && dst < NC && q[dst].size() == DEPTH;
    endfunction

    function automatic logic [2:0] pick(input int mode, input bit en);
        if (!en) return 3'b000;
        if (mode == 1) return 3'($urandom);
        if (mode == 2) return 3'b111;
        return 3'b000;
    endfunction

    task automatic tick(input logic [7:0] d, input logic pv, output bit acc);
        logic [23:0] ed;
        logic [2:0]  ev;
        bit          b, n_err, n_aerr;
        bit          fl [NC];
        bit          pp [NC];
        int          sz [NC];
        int          dst;
        @(negedge clk);
        bus.data_in   = d;
        bus.pkt_valid = pv;
        bus.read_en   = rd_req;
        #1;
        ed = '0;
        ev = '0;
        for (int k = 0; k < NC; k++) begin
            sz[k] = q[k].size();
            if (sz[k] > 0) begin
                ev[k] = 1'b1;
                ed[k*8 +: 8] = q[k][0];
            end
        end
        b = exp_busy(d, pv);
        check("busy",      32'(bus.busy),      32'(b));
        check("valid_out", 32'(bus.valid_out), 32'(ev));
        check("data_out",  32'(bus.data_out),  32'(ed));
        check("error",     32'(bus.error),     32'(m_err));
        check("addr_err",  32'(bus.addr_err),  32'(m_aerr));

        for (int k = 0; k < NC; k++) begin
            fl[k] = FLUSH && sz[k] > 0 && !rd_req[k] && tcnt[k] == TIMEOUT - 1;
            pp[k] = rd_req[k] && sz[k] > 0 && !fl[k];
        end
        acc = !b;
        n_err = 0;
        n_aerr = 0;
        if (bubble) begin
            bubble = 0;
        end else if (dropping) begin
            if (!pv) dropping = 0;
        end else if (in_pkt) begin
            if (acc && !pv) begin
                if (!fl[mdest]) begin
                    q[mdest].push_back(d);
                    n_err = (d != mpar);
                end
                in_pkt = 0;
                bubble = 1;
            end else if (fl[mdest]) begin
                in_pkt = 0;
                dropping = 1;
            end else if (acc) begin
                q[mdest].push_back(d);
                mpar ^= d;
            end
        end else if (pv) begin
            dst = int'(d[1:0]);
            if (dst >= NC) begin
                n_aerr = 1;
                dropping = 1;
            end else if (acc) begin
                if (fl[dst]) dropping = 1;
                else begin
                    q[dst].push_back(d);
                    mdest = dst;
                    mpar = d;
                    in_pkt = 1;
                end
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (pp[k]) void'(q[k].pop_front());
            if (fl[k]) q[k].delete();
            if (fl[k] || sz[k] == 0 || rd_req[k]) tcnt[k] = 0;
            else tcnt[k]++;
        end
        m_err = n_err;
        m_aerr = n_aerr;
    endtask

    task automatic send_words(input logic [7:0] w[$], input int mode, input int delay);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < w.size() && cyc < 2000) begin
            rd_req = pick(mode, cyc >= delay);
            tick(w[i], i != w.size() - 1, acc);
            if (acc) i++;
            cyc++;
        end
        check("pkt_done", 32'(i), 32'(w.size()));
    endtask

    task automatic build_pkt(input logic [7:0] hdr, input int npay, input bit bad,
                             output logic [7:0] w[$]);
        logic [7:0] par, b;
        w.delete();
        w.push_back(hdr);
        par = hdr;
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            w.push_back(b);
            par ^= b;
        end
        w.push_back(bad ? par ^ 8'h01 : par);
    endtask

    task automatic idle(input int n, input int mode);
        bit acc;
        for (int i = 0; i < n; i++) begin
            rd_req = pick(mode, 1'b1);
            tick(8'($urandom), 1'b0, acc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy),      32'd0);
        check({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_data"},  32'(bus.data_out),  32'd0);
        check({tag, "_err"},   32'(bus.error),     32'd0);
        check({tag, "_aerr"},  32'(bus.addr_err),  32'd0);
    endtask

    initial begin
        logic [7:0] w[$];
        bit acc;
        bus.data_in = '0;
        bus.pkt_valid = 1'b0;
        bus.read_en = '0;
        rd_req = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        w = '{8'h01, 8'h11, 8'h22, 8'h32};
        send_words(w, 0, 0);
        idle(3, 0);
        idle(6, 2);

        w = '{8'h01, 8'h11, 8'h22, 8'h33};
        send_words(w, 0, 0);
        idle(3, 0);
        idle(6, 2);

        build_pkt(8'h03, 2, 1'b0, w);
        send_words(w, 0, 0);
        build_pkt(8'h00, 3, 1'b0, w);
        send_words(w, 0, 0);
        idle(8, 2);

        build_pkt(8'h02, 18, 1'b0, w);
        send_words(w, 2, 20);
        idle(20, 2);

        build_pkt(8'h00, 3, 1'b0, w);
        send_words(w, 0, 0);
        idle(40, 0);
        idle(20, 2);

        build_pkt(8'h01, 6, 1'b0, w);
        rd_req = '0;
        tick(w[0], 1'b1, acc);
        tick(w[1], 1'b1, acc);
        tick(w[2], 1'b1, acc);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        bus.pkt_valid = 1'b0;
        bus.read_en = '0;
        @(negedge clk);
        rstn = 1'b1;
        build_pkt(8'h01, 4, 1'b0, w);
        send_words(w, 0, 0);
        idle(10, 2);

        for (int p = 0; p < 150; p++) begin
            build_pkt(8'($urandom), $urandom_range(0, 18), $urandom_range(0, 3) == 0, w);
            send_words(w, 1, $urandom_range(0, 25));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5), 1);
        end
        idle(60, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised single-input, N-output packet router, the next generation of the 1x3 router. It accepts byte-serial packets on one input port, decodes the destination from the header, buffers each packet into one of `NUM_CH` output FIFOs, checks trailing parity, and flushes abandoned FIFOs after a programmable timeout. Unlike the 1x3 router, it drops packets addressed to a nonexistent channel and reports them with a dedicated flag.

## Interface
- `DATA_W`, 8: word width; the header carries `ADDR_W` destination bits in `[ADDR_W-1:0]`.
- `NUM_CH`, 3: output channel count, 2..16.
- `ADDR_W`, `$clog2(NUM_CH)`: destination field width.
- `DEPTH`, 16: entries per channel FIFO, power of 2.
- `TIMEOUT`, 30: idle cycles before a soft reset (flush), 1..1023.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_W  input word (header, payload, or parity).
- `pkt_valid`  in  1  high for the header and payload words; low for the parity word.
- `busy`  out  1  combinational; when high, the source holds `data_in`/`pkt_valid` unchanged.
- `read_en`  in  NUM_CH  per-channel pop request.
- `valid_out`  out  NUM_CH  per-channel FIFO not empty.
- `data_out`  out  NUM_CH*DATA_W  per-channel head word, show-ahead; channel k is at `[k*DATA_W +: DATA_W]`.
- `error`  out  1  one-cycle parity-mismatch pulse.
- `addr_err`  out  1  one-cycle pulse when a header addresses a channel >= NUM_CH.

## Operation
- Reset values: `busy`=0, `valid_out`=0, `data_out`=0, `error`=0, `addr_err`=0; FSM in IDLE; all FIFOs empty; timeout counters at 0.
- Word acceptance: a word is accepted when the FSM is in IDLE, LOAD or DROP and `busy`=0. In IDLE, the FSM reacts only while `pkt_valid`=1.
- IDLE:
  - If `dest` >= NUM_CH: pulse `addr_err` and go to DROP.
  - Else `busy` = `full[dest]`. On acceptance, write the header to FIFO `dest`, latch `dest`, seed parity = header, and go to LOAD.
- LOAD:
  - `busy` = `full[dest_reg]`.
  - Each accepted word is written to the FIFO and XORed into parity.
  - An accepted word with `pkt_valid`=0 is the parity byte. It is written, compared against the running parity, and the FSM goes to CHECK.
- CHECK: one cycle, `busy`=1. `error` is 1 this cycle iff the comparison mismatched. Then go to IDLE.
- DROP: `busy`=0. Accepted words are discarded. After the word with `pkt_valid`=0 is accepted, go to IDLE.
- FIFO k:
  - Show-ahead: `data_out[k]` presents the head word while `valid_out[k]`=1.
  - `read_en[k]` with `valid_out[k]`=1 pops on the edge.
  - `read_en[k]` while empty is ignored; no underflow.
  - Full: `full[k]` ignores a same-cycle pop. Full therefore stalls the source for one cycle even when a pop is occurring.
  - Pointers are ADDR-width+1 so wrap-around is unambiguous; full = MSBs differ and LSBs equal.
- Soft reset (see Configuration):
  - Counter k increments while `valid_out[k]`=1 and `read_en[k]`=0.
  - It clears on any pop or while the FIFO is empty.
  - Reaching TIMEOUT flushes FIFO k (pointers to 0) and clears the counter.
- Simultaneous events:
  - A flush wins over a same-cycle write and a same-cycle pop.
  - If the flushed FIFO is `dest_reg` during LOAD, the FSM goes to DROP for the packet remainder, with no `error` pulse.
- Reset mid-packet: everything returns to the reset values immediately; the partial packet is lost.

## Timing
- Write-to-output latency: a word written on edge n shows `valid_out`/`data_out` after edge n; it is visible in cycle n+1.
- Minimum packet (header + parity) occupancy: 3 cycles (IDLE accept, LOAD accept, CHECK). Back-to-back packets need one bubble cycle (CHECK).
- `busy` is combinational from the FSM state, the selected `full`, and `data_in` (in IDLE).
- `error` and `addr_err` are registered and high for exactly one cycle.
- The flush takes effect on the edge where the counter reaches TIMEOUT; `valid_out` is 0 in the next cycle.

## Configuration
- `ROUTER_TIMEOUT_FLUSH_EN` defined: timeout counters and soft-reset flush are present as above.
- Not defined: no counters and no flushing. FIFOs hold data indefinitely, and the LOAD-to-DROP abort path does not exist.

## Test plan
All scenarios use NUM_CH=3, DATA_W=8, DEPTH=16, TIMEOUT=30, with `ROUTER_TIMEOUT_FLUSH_EN` defined.
- Packet header 0x01, payload 0x11 0x22, parity 0x32 -> FIFO1 holds 4 words; `error`=0; `valid_out`=3'b010; popping returns 01,11,22,32 in order.
- Same packet with parity 0x33 -> `error` high for exactly 1 cycle in CHECK; all 4 words are still stored.
- Header 0x03 plus 2 payload words and parity -> `addr_err` pulses once; no FIFO changes; the next valid packet to ch0 is routed normally.
- 20-word packet to ch2 with `read_en[2]`=0 -> `busy` rises when 16 words are stored; asserting `read_en[2]` drains the FIFO; the packet completes with no loss and correct order.
- 5-word packet to ch0, never read -> `valid_out[0]` drops 30 cycles after the FIFO becomes non-empty and after the last pop; `data_out[0]` is stale-invisible.
- Deassert `rstn` mid-payload to ch1 -> all outputs go to 0 asynchronously; after release, a new packet to ch1 is accepted from IDLE.
